// File: rtl/lfsr_pkg.sv
// Shared definitions for the 5-bit LFSR pattern generator and checker.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
// Ports: none. Provides LFSR_W, the tap positions, the reset seed, the
// checker state type and lfsr_next_bit(), so the polynomial lives in one place.
package lfsr_pkg;

   localparam int LFSR_W = 5;
   localparam int TAP_HI = 4;
   localparam int TAP_LO = 3;
   localparam logic [LFSR_W-1:0] LFSR_SEED = 5'd1;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } lfsr_state_t;

   // Next bit of the recurrence b[n] = b[n-4] ^ b[n-5]. Bit 0 of the
   // register is the newest bit, so b[n-5] sits in bit 4 and b[n-4] in bit 3.
   function automatic logic lfsr_next_bit(input logic [LFSR_W-1:0] shadow);
      return shadow[TAP_HI] ^ shadow[TAP_LO];
   endfunction

endpackage

// File: rtl/lfsr_checker.sv
// Serial 5-bit LFSR pattern checker: self-syncs, locks, counts errors, drops lock on error bursts.
// Latency: 1 cycle; every output reflects the bit accepted on the previous rising edge.
// Backpressure: none; a bit is consumed on every in_valid cycle, and idle cycles hold all state.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   in_valid   in_bit is valid this cycle
//   in_bit     serial pattern bit
//   clear      synchronous zero of err_count and bit_count; lock state untouched
//   locked     checker is in LOCKED
//   err_pulse  one-cycle pulse: the last accepted bit mismatched while LOCKED
//   err_count  saturating count of errors seen while LOCKED
//   bit_count  saturating count of bits accepted while LOCKED
module lfsr_checker
   import lfsr_pkg::*;
#(
   parameter int LOCK_CNT = 8,
   parameter int WIN      = 32,
   parameter int LOSS_THR = 4,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic             clear,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] bit_count
);

   localparam int MATCH_W = $clog2(LOCK_CNT + 1);
   localparam int WPOS_W  = $clog2(WIN + 1);
   localparam int WERR_W  = $clog2(LOSS_THR + 1);

   localparam logic [2:0]         FILL_FULL  = 3'(LFSR_W);
   localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
   localparam logic [WPOS_W-1:0]  WPOS_LAST  = WPOS_W'(WIN - 1);
   localparam logic [WERR_W-1:0]  WERR_LAST  = WERR_W'(LOSS_THR - 1);

   lfsr_state_t         r_state;
   logic [LFSR_W-1:0]   r_shadow;
   logic [2:0]          r_fill;
   logic [MATCH_W-1:0]  r_match;
   logic [WPOS_W-1:0]   r_wpos;
   logic [WERR_W-1:0]   r_werr;
   logic                r_err_pulse;
   logic [CNT_W-1:0]    r_err_count;
   logic [CNT_W-1:0]    r_bit_count;

   lfsr_state_t         w_state_nxt;
   logic [LFSR_W-1:0]   w_shadow_nxt;
   logic [2:0]          w_fill_nxt;
   logic [MATCH_W-1:0]  w_match_nxt;
   logic [WPOS_W-1:0]   w_wpos_nxt;
   logic [WERR_W-1:0]   w_werr_nxt;
   logic                w_pulse_nxt;
   logic                w_err_inc;
   logic                w_bit_inc;
   logic                w_pred;
   logic                w_mism;

   assign w_pred = lfsr_next_bit(r_shadow);
   assign w_mism = (in_bit != w_pred);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= HUNT;
         r_shadow <= '0;
         r_fill   <= '0;
         r_match  <= '0;
         r_wpos   <= '0;
         r_werr   <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_shadow <= w_shadow_nxt;
         r_fill   <= w_fill_nxt;
         r_match  <= w_match_nxt;
         r_wpos   <= w_wpos_nxt;
         r_werr   <= w_werr_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_shadow_nxt = r_shadow;
      w_fill_nxt   = r_fill;
      w_match_nxt  = r_match;
      w_wpos_nxt   = r_wpos;
      w_werr_nxt   = r_werr;
      w_pulse_nxt  = 1'b0;
      w_err_inc    = 1'b0;
      w_bit_inc    = 1'b0;

      if (in_valid) begin
         case (r_state)
            HUNT: begin
               // Self-sync: the received stream itself seeds the reference.
               w_shadow_nxt = {r_shadow[LFSR_W-2:0], in_bit};
               if (r_fill != FILL_FULL) begin
                  w_fill_nxt = r_fill + 1'b1;
               end else if (!w_mism && (r_shadow != '0)) begin
                  // All-zero is a fixed point of the recurrence, so it never
                  // counts towards lock even though it "predicts" correctly.
                  if (r_match == MATCH_LAST) begin
                     w_state_nxt = LOCKED;
                     w_match_nxt = '0;
                  end else begin
                     w_match_nxt = r_match + 1'b1;
                  end
               end else begin
                  w_match_nxt = '0;
               end
            end

            LOCKED: begin
               // Free-running reference: a bad input bit must not corrupt
               // the predictions of the bits that follow it.
               w_shadow_nxt = {r_shadow[LFSR_W-2:0], w_pred};
               w_bit_inc    = 1'b1;
               if (w_mism) begin
                  w_pulse_nxt = 1'b1;
                  w_err_inc   = 1'b1;
               end
               if (w_mism && (r_werr == WERR_LAST)) begin
                  w_state_nxt  = HUNT;
                  w_shadow_nxt = '0;
                  w_fill_nxt   = '0;
                  w_match_nxt  = '0;
                  w_wpos_nxt   = '0;
                  w_werr_nxt   = '0;
               end else if (r_wpos == WPOS_LAST) begin
                  // Windows are back to back; errors never carry over.
                  w_wpos_nxt = '0;
                  w_werr_nxt = '0;
               end else begin
                  w_wpos_nxt = r_wpos + 1'b1;
                  if (w_mism) begin
                     w_werr_nxt = r_werr + 1'b1;
                  end
               end
            end
         endcase
      end
   end

   // Pulse and statistics counters; clear beats a same-cycle increment.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_err_pulse <= 1'b0;
         r_err_count <= '0;
         r_bit_count <= '0;
      end else begin
         r_err_pulse <= w_pulse_nxt;
         if (clear) begin
            r_err_count <= '0;
         end else if (w_err_inc && (r_err_count != '1)) begin
            r_err_count <= r_err_count + 1'b1;
         end
         if (clear) begin
            r_bit_count <= '0;
         end else if (w_bit_inc && (r_bit_count != '1)) begin
            r_bit_count <= r_bit_count + 1'b1;
         end
      end
   end

   assign locked    = (r_state == LOCKED);
   assign err_pulse = r_err_pulse;
   assign err_count = r_err_count;
   assign bit_count = r_bit_count;

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: a default-width instance and a 4-bit
// counter instance share one stimulus stream and one reference model.
module tb_lfsr_checker;

   localparam int LOCK_CNT = 8;
   localparam int WIN      = 32;
   localparam int LOSS_THR = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_bit;
   logic        clear;
   logic        locked_a, pulse_a;
   logic [15:0] errc_a, bitc_a;
   logic        locked_b, pulse_b;
   logic [3:0]  errc_b, bitc_b;

   always #5 clk = ~clk;

   lfsr_checker u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
      .locked(locked_a), .err_pulse(pulse_a), .err_count(errc_a), .bit_count(bitc_a)
   );

   lfsr_checker #(.CNT_W(4)) u_small (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
      .locked(locked_b), .err_pulse(pulse_b), .err_count(errc_b), .bit_count(bitc_b)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- pattern source: generator seeded 5'd1 ----------------
   logic [4:0] gen_s;
   function automatic bit gen_next();
      gen_s = {gen_s[3:0], gen_s[4] ^ gen_s[3]};
      return gen_s[0];
   endfunction

   // ---------------- reference model (history-based) ----------------
   bit m_hist[$];   // received bits in HUNT, predicted bits in LOCKED
   int m_match, m_wpos, m_werr, m_errs, m_bits;
   bit m_locked, m_pulse;

   task automatic model_reset();
      m_hist.delete();
      m_match = 0; m_wpos = 0; m_werr = 0; m_errs = 0; m_bits = 0;
      m_locked = 0; m_pulse = 0;
   endtask

   task automatic model_step(input bit v, input bit b, input bit c);
      bit pred;
      bit allz;
      int n;
      m_pulse = 0;
      if (v) begin
         n = m_hist.size();
         if (!m_locked) begin
            if (n >= 5) begin
               pred = m_hist[n-4] ^ m_hist[n-5];
               allz = 1;
               for (int i = n - 5; i < n; i++) if (m_hist[i]) allz = 0;
               if (b == pred && !allz) m_match++;
               else m_match = 0;
            end
            m_hist.push_back(b);
            if (m_match == LOCK_CNT) begin
               m_locked = 1;
               m_match  = 0;
            end
         end else begin
            pred = m_hist[n-4] ^ m_hist[n-5];
            m_hist.push_back(pred);
            m_bits++;
            m_wpos++;
            if (b != pred) begin
               m_pulse = 1; m_errs++; m_werr++;
            end
            if (m_werr == LOSS_THR) begin
               m_locked = 0; m_hist.delete(); m_match = 0; m_wpos = 0; m_werr = 0;
            end else if (m_wpos == WIN) begin
               m_wpos = 0; m_werr = 0;
            end
         end
      end
      if (c) begin
         m_errs = 0; m_bits = 0;
      end
   endtask

   function automatic int sat(input int v, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   task automatic check_all();
      chk("locked",    locked_a, m_locked);
      chk("err_pulse", pulse_a,  m_pulse);
      chk("err_count", errc_a,   sat(m_errs, 16));
      chk("bit_count", bitc_a,   sat(m_bits, 16));
      chk("small_locked",    locked_b, m_locked);
      chk("small_err_pulse", pulse_b,  m_pulse);
      chk("small_err_count", errc_b,   sat(m_errs, 4));
      chk("small_bit_count", bitc_b,   sat(m_bits, 4));
   endtask

   // Drive at negedge, let the rising edge accept, sample 1 time unit later.
   task automatic step(input bit v, input bit b, input bit c);
      @(negedge clk);
      in_valid = v; in_bit = b; clear = c;
      @(posedge clk);
      #1;
      model_step(v, b, c);
      check_all();
   endtask

   task automatic send(input bit flip);
      bit b;
      b = gen_next() ^ flip;
      step(1'b1, b, 1'b0);
   endtask

   // Asynchronous reset: outputs must be zero before any clock edge.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0; clear = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      rst = 1'b1;
   endtask

   // ---------------- table of vectors: clean stream with valid gaps ----------------
   typedef struct {
      bit v;
      bit b;
      bit c;
      bit exp_locked;
      bit exp_pulse;
   } vec_t;

   vec_t tbl[20];
   int   vc;
   bit   any_drop;
   bit   lock_seen;
   int   guard;
   bit   rv, rf, rc, rb;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clear = 1'b0;
      gen_s = 5'd1;
      model_reset();
      #1 rst = 1'b0;
      #1 check_all();
      @(negedge clk);
      rst = 1'b1;

      // Lock takes exactly 5 + LOCK_CNT valid bits; idle cycles do not count.
      vc = 0;
      for (int i = 0; i < 20; i++) begin
         tbl[i].v = !(i == 3 || i == 7 || i == 10);
         tbl[i].b = tbl[i].v ? gen_next() : 1'($urandom);
         tbl[i].c = 1'b0;
         if (tbl[i].v) vc++;
         tbl[i].exp_locked = (vc >= 5 + LOCK_CNT);
         tbl[i].exp_pulse  = 1'b0;
      end
      for (int i = 0; i < 20; i++) begin
         step(tbl[i].v, tbl[i].b, tbl[i].c);
         chk("tbl_locked", locked_a, tbl[i].exp_locked);
         chk("tbl_pulse",  pulse_a,  tbl[i].exp_pulse);
      end

      // Clean stream up to 200 bits total: no errors.
      repeat (200 - vc) send(1'b0);
      chk("clean_err_count", errc_a, 0);
      chk("clean_locked", locked_a, 1);

      // Single flipped bit: one pulse, one error, lock kept.
      send(1'b1);
      chk("single_pulse", pulse_a, 1);
      chk("single_err_count", errc_a, 1);
      chk("single_locked", locked_a, 1);
      repeat (10) send(1'b0);
      chk("single_after_err_count", errc_a, 1);

      // Four flips in one fresh window: lock drops right after the fourth.
      guard = 0;
      while (m_wpos != 0 && guard < 64) begin send(1'b0); guard++; end
      for (int k = 0; k < 16; k++) send(k % 5 == 0);
      chk("loss_locked", locked_a, 0);
      chk("loss_pulse", pulse_a, 1);
      chk("loss_err_count", errc_a, 5);
      for (int j = 1; j <= 5 + LOCK_CNT; j++) begin
         send(1'b0);
         if (j == 4 + LOCK_CNT) chk("relock_early", locked_a, 0);
         if (j == 5 + LOCK_CNT) chk("relock", locked_a, 1);
      end

      // Three flips per window never lose lock; 4-bit counter saturates.
      step(1'b0, 1'b0, 1'b1);
      chk("clear_err_count", errc_a, 0);
      any_drop = 0;
      guard = 0;
      while (m_wpos != 0 && guard < 64) begin send(1'b0); guard++; end
      for (int w = 0; w < 6; w++) begin
         for (int k = 0; k < WIN; k++) begin
            send(k == 1 || k == 10 || k == 20);
            if (!locked_a) any_drop = 1;
         end
         if (w == 3) chk("win3_err_count", errc_a, 12);
      end
      chk("win_no_drop", any_drop, 0);
      chk("win6_err_count", errc_a, 18);
      chk("small_sat_err_count", errc_b, 4'hF);

      // Clear with a simultaneous error: clear wins, pulse still fires.
      rb = gen_next() ^ 1'b1;
      step(1'b1, rb, 1'b1);
      chk("clear_vs_err_count", errc_a, 0);
      chk("clear_vs_err_pulse", pulse_a, 1);

      // Reset mid-lock, then relock counting valid bits only.
      chk("pre_reset_locked", locked_a, 1);
      do_reset();
      vc = 0;
      while (vc < 5 + LOCK_CNT) begin
         if (vc % 3 == 1) step(1'b0, 1'($urandom), 1'b0);
         send(1'b0);
         vc++;
         if (vc == 4 + LOCK_CNT) chk("rst_relock_early", locked_a, 0);
      end
      chk("rst_relock", locked_a, 1);

      // Constant zero stream never locks.
      do_reset();
      lock_seen = 0;
      repeat (100) begin
         step(1'b1, 1'b0, 1'b0);
         if (locked_a) lock_seen = 1;
      end
      chk("zeros_never_lock", lock_seen, 0);

      // Randomised traffic: gaps, sparse bit flips, occasional clear.
      for (int i = 0; i < 3000; i++) begin
         rv = ($urandom_range(0, 7) != 0);
         rf = ($urandom_range(0, 19) == 0);
         rc = ($urandom_range(0, 99) == 0);
         if (rv) rb = gen_next() ^ rf;
         else    rb = 1'($urandom);
         step(rv, rb, rc);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
